ahmes_control_unit: RTL and testbench
=====================================

Name: ahmes_control_unit

Overview:
Instruction sequencer for the Ahmes CPU. It sits directly upstream of the PC register and drives its inc/load/pc_in. It fetches the opcode and the operand byte from the shared memory, decodes the Ahmes ISA and evaluates jump conditions against the datapath flags. It issues the memory, accumulator and ALU control strobes.

Parameters:
WIDTH, 8, data and address width in bits; the decode rules below assume 8.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
pc_out  in  WIDTH  current PC value from the PC register
pc_inc  out  1  PC increment strobe
pc_load  out  1  PC load strobe
pc_in  out  WIDTH  jump target presented to the PC
mem_addr  out  WIDTH  memory address
mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_addr
mem_we  out  1  memory write strobe; the datapath drives the write data from AC
ac_load  out  1  accumulator and flags update strobe
alu_op  out  4  0 PASS, 1 ADD, 2 OR, 3 AND, 4 NOT, 5 SUB, 6 SHR, 7 SHL, 8 ROR, 9 ROL
operand  out  WIDTH  ALU B operand, equal to mem_rdata
flag_n, flag_z, flag_v, flag_c, flag_b  in  1 each  datapath flags
ir  out  WIDTH  instruction register
halt  out  1  high while in HALT

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, ir=0, addr_reg=0.
  - pc_inc, pc_load, mem_we, ac_load and halt are 0; alu_op=0; pc_in=0.
  - The same reset clears the PC externally.
- Output timing: all strobes are combinational from state and ir, active for exactly one cycle. pc_inc and pc_load are never high together.
- Memory model: synchronous read with 1-cycle latency.
- Opcode decode on ir[7:4]:
  - 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 7 SUB, 8 JMP.
  - 9: ir[3:2] selects JN, JP, JV, JNV.
  - A: ir[3:2] selects JZ, JNZ; ir[3:2]=2 or 3 is NOP.
  - B: ir[3:2] selects JC, JNC, JB, JNB.
  - E: ir[1:0] selects SHR, SHL, ROR, ROL.
  - F HLT.
  - C and D are NOP.
- Jump conditions:
  - JP is taken when N=0 and Z=0.
  - All other conditional jumps test their named flag directly (true or false variant).
  - Flags are sampled in OPADDR.
- States:
  - FETCH: mem_addr=pc_out. Next: IR.
  - IR: ir<=mem_rdata; pc_inc=1. Next: DECODE.
  - DECODE, by opcode:
    - NOP: next FETCH.
    - NOT or shift: ac_load=1 with the matching alu_op; next FETCH.
    - HLT: next HALT.
    - Otherwise: mem_addr=pc_out; next OPADDR.
  - OPADDR: addr_reg<=mem_rdata.
    - Jump taken: pc_load=1, pc_in=mem_rdata.
    - Jump not taken, or memory-operand op: pc_inc=1.
    - Next: FETCH for jumps, EXEC otherwise.
  - EXEC: mem_addr=addr_reg.
    - STA: mem_we=1; next FETCH.
    - Otherwise: next WB.
  - WB: ac_load=1; alu_op is PASS for LDA, else the op's code. Next: FETCH.
  - HALT: halt=1, no strobes; the only exit is reset.
- Cycle counts:
  - NOP, NOT, shift: 3.
  - Any jump, taken or not: 4.
  - STA: 5.
  - LDA, ADD, OR, AND, SUB: 6.
- mem_addr holds pc_out in every state that does not drive it explicitly.
- PC wrap-around: 0xFF+1 wraps to 0x00 inside the PC; a fetch at 0xFF with its operand at 0x00 is legal.
- Reset mid-instruction: abandons the instruction and all strobes drop immediately (asynchronous). An in-flight STA must not write after reset is asserted.

Test Plan:
- Memory 0x00=0x20, 0x01=0x80, 0x80=0x5A: after reset release → pc_inc in cycles 2 and 4, mem_addr=0x80 in cycle 5, ac_load with alu_op=0 and operand=0x5A in cycle 6, PC=0x02.
- JMP 0x10 at 0x00 → pc_load=1 with pc_in=0x10 in cycle 4, then the next FETCH drives mem_addr=0x10.
- JZ 0x40 (0xA0) with flag_z=0 → no pc_load, PC=0x02 after 4 cycles. Same with flag_z=1 → PC=0x40. Repeat for JNB (0xBC) with flag_b=0 → taken.
- STA 0x30 (0x10 0x30) → mem_we=1 with mem_addr=0x30 in exactly one cycle (cycle 5), and ac_load stays 0 throughout.
- Sequence NOP, SHL (0xE1), HLT → 3-cycle NOP; ac_load with alu_op=7 in the SHL DECODE cycle; then halt=1 at PC=0x03 with no strobes for 20 cycles.
- Assert reset during the EXEC cycle of STA → mem_we drops immediately, state returns to FETCH, ir=0. After release, fetch restarts from 0x00.

Source files
------------

// File: rtl/ahmes_control_unit.sv
// ahmes_control_unit: Ahmes CPU instruction sequencer (fetch, decode, jump evaluation, datapath strobes)
module ahmes_control_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_out,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_we,
  output logic             ac_load,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] operand,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_v,
  input  logic             flag_c,
  input  logic             flag_b,
  output logic [WIDTH-1:0] ir,
  output logic             halt
);
  typedef enum logic [2:0] {S_FETCH, S_IR, S_DECODE, S_OPADDR, S_EXEC, S_WB, S_HALT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] addr_reg;
  logic [3:0] op, op_code;
  logic [1:0] sel, sh;
  logic is_jmp, is_unary, is_nop, is_hlt, is_sta, j9, ja, jb, taken;
  assign op  = ir[7:4];
  assign sel = ir[3:2];
  assign sh  = ir[1:0];
  // Opcode classification, jump condition and ALU code derived from the instruction register
  always_comb begin
    is_jmp   = op == 4'h8 || op == 4'h9 || op == 4'hB || (op == 4'hA && !sel[1]);
    is_unary = op == 4'h6 || op == 4'hE;
    is_nop   = op == 4'h0 || op == 4'hC || op == 4'hD || (op == 4'hA && sel[1]);
    is_hlt   = op == 4'hF;
    is_sta   = op == 4'h1;
    j9       = sel == 2'd0 ? flag_n : sel == 2'd1 ? (!flag_n && !flag_z) : sel == 2'd2 ? flag_v : !flag_v;
    ja       = sel[0] ? !flag_z : flag_z;
    jb       = sel == 2'd0 ? flag_c : sel == 2'd1 ? !flag_c : sel == 2'd2 ? flag_b : !flag_b;
    taken    = op == 4'h8 || (op == 4'h9 && j9) || (op == 4'hA && !sel[1] && ja) || (op == 4'hB && jb);
    op_code  = op == 4'h3 ? 4'd1 : op == 4'h4 ? 4'd2 : op == 4'h5 ? 4'd3 : op == 4'h6 ? 4'd4 :
               op == 4'h7 ? 4'd5 : op == 4'hE ? 4'd6 + {2'b00, sh} : 4'd0;
  end
  // Next-state sequencing and combinational strobes from state and ir
  always_comb begin
    state_nx = state;
    pc_inc   = state == S_IR || (state == S_OPADDR && !taken);
    pc_load  = state == S_OPADDR && taken;
    pc_in    = pc_load ? mem_rdata : '0;
    mem_addr = state == S_EXEC ? addr_reg : pc_out;
    mem_we   = state == S_EXEC && is_sta;
    ac_load  = (state == S_DECODE && is_unary) || state == S_WB;
    alu_op   = ac_load ? op_code : 4'd0;
    operand  = mem_rdata;
    halt     = state == S_HALT;
    state_nx = state == S_FETCH  ? S_IR :
               state == S_IR     ? S_DECODE :
               state == S_DECODE ? ((is_nop || is_unary) ? S_FETCH : is_hlt ? S_HALT : S_OPADDR) :
               state == S_OPADDR ? (is_jmp ? S_FETCH : S_EXEC) :
               state == S_EXEC   ? (is_sta ? S_FETCH : S_WB) :
               state == S_WB     ? S_FETCH : S_HALT;
  end
  // State, instruction and operand-address registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      addr_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IR) ir <= mem_rdata;
      if (state == S_OPADDR) addr_reg <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_ahmes_control_unit.sv
// tb_ahmes_control_unit: table-driven and sequence checks of the Ahmes sequencer with PC and memory models
module tb_ahmes_control_unit;
  typedef struct {
    logic [7:0] ins, opr;
    logic [4:0] flg;
    int         cyc;
    logic [7:0] pc, incm;
    int         ld, acl;
    logic [3:0] alu;
    int         we;
  } vec_t;
  typedef struct {
    logic [7:0] incm, pcin, opd, wa, a5;
    int         ld, acl, we, both, hlt;
    logic [3:0] alu;
  } obs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ld = 1'b0;
  logic [7:0] pc_out, pc_in, mem_addr, mem_rdata, operand, ir;
  logic pc_inc, pc_load, mem_we, ac_load, halt;
  logic fn = 1'b0, fz = 1'b0, fv = 1'b0, fc = 1'b0, fb = 1'b0;
  logic [3:0] alu_op;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] cur_ins;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  ahmes_control_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .ac_load(ac_load), .alu_op(alu_op),
    .operand(operand), .flag_n(fn), .flag_z(fz), .flag_v(fv), .flag_c(fc), .flag_b(fb), .ir(ir), .halt(halt)
  );
  // PC register model sharing the sequencer's reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_out <= 8'h00;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc) pc_out <= pc_out + 8'd1;
  end
  // Synchronous memory with one-cycle read latency; ld copies the image in, writes store a fixed AC value
  always @(posedge clk) begin
    if (ld) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    else if (mem_we) mem[mem_addr] <= 8'hCC;
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ins=%02h: got %0h, expected %0h", nm, cur_ins, act, exp);
    end
  endtask
  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h80] = 8'h5A;
    img[8'h30] = 8'h77;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ld = 1'b1;
    #1;
    chk("reset_state", {pc_inc, pc_load, mem_we, ac_load, halt, alu_op, pc_in, ir}, 0);
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic window(input int n, output obs_t o);
    o = '{default: 0};
    for (int c = 0; c < n; c++) begin
      #1;
      if (pc_inc) o.incm[c] = 1'b1;
      if (pc_inc && pc_load) o.both++;
      if (halt) o.hlt++;
      if (pc_load) begin o.ld++; o.pcin = pc_in; end
      if (ac_load) begin o.acl++; o.alu = alu_op; o.opd = operand; end
      if (mem_we) begin o.we++; o.wa = mem_addr; end
      if (c == 4) o.a5 = mem_addr;
      @(negedge clk);
    end
  endtask
  function automatic vec_t mk(input logic [7:0] ins, opr, input logic [4:0] flg, input int cyc,
                              input logic [7:0] pc, incm, input int ldn, acl, input logic [3:0] alu, input int we);
    vec_t v;
    v.ins = ins; v.opr = opr; v.flg = flg; v.cyc = cyc; v.pc = pc; v.incm = incm;
    v.ld = ldn; v.acl = acl; v.alu = alu; v.we = we;
    return v;
  endfunction
  task automatic run_vec(input vec_t v);
    obs_t o;
    vec_t e;
    cur_ins = v.ins;
    clear_img();
    img[0] = v.ins;
    img[1] = v.opr;
    {fn, fz, fv, fc, fb} = v.flg;
    do_reset();
    exp_q.push_back(v);
    window(v.cyc, o);
    e = exp_q.pop_front();
    #1;
    chk("next_fetch_addr", mem_addr, e.pc);
    chk("fetch_idle", {pc_inc, pc_load, ac_load, mem_we}, 0);
    chk("pc_value", pc_out, e.pc);
    chk("pc_inc_cycles", o.incm, e.incm);
    chk("pc_load_count", o.ld, e.ld);
    chk("ac_load_count", o.acl, e.acl);
    chk("mem_we_count", o.we, e.we);
    chk("inc_and_load", o.both, 0);
    chk("halt_seen", o.hlt, 0);
    if (e.ld != 0) chk("pc_in", o.pcin, e.opr);
    if (e.acl != 0) chk("alu_op", o.alu, e.alu);
    if (e.cyc == 6) chk("wb_operand", o.opd, 8'h5A);
    if (e.cyc >= 5) chk("exec_addr", o.a5, e.opr);
    if (e.we != 0) chk("we_addr", o.wa, e.opr);
  endtask
  initial begin
    obs_t o;
    vecs.push_back(mk(8'h00, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h20, 8'h80, 5'b00000, 6, 8'h02, 8'h0A, 0, 1, 4'd0, 0));
    vecs.push_back(mk(8'h30, 8'h80, 5'b00000, 6, 8'h02, 8'h0A, 0, 1, 4'd1, 0));
    vecs.push_back(mk(8'h40, 8'h80, 5'b00000, 6, 8'h02, 8'h0A, 0, 1, 4'd2, 0));
    vecs.push_back(mk(8'h50, 8'h80, 5'b00000, 6, 8'h02, 8'h0A, 0, 1, 4'd3, 0));
    vecs.push_back(mk(8'h70, 8'h80, 5'b00000, 6, 8'h02, 8'h0A, 0, 1, 4'd5, 0));
    vecs.push_back(mk(8'h10, 8'h30, 5'b00000, 5, 8'h02, 8'h0A, 0, 0, 4'd0, 1));
    vecs.push_back(mk(8'h60, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 1, 4'd4, 0));
    vecs.push_back(mk(8'hE0, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 1, 4'd6, 0));
    vecs.push_back(mk(8'hE5, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 1, 4'd7, 0));
    vecs.push_back(mk(8'hEA, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 1, 4'd8, 0));
    vecs.push_back(mk(8'hEF, 8'h55, 5'b00000, 3, 8'h01, 8'h02, 0, 1, 4'd9, 0));
    vecs.push_back(mk(8'h80, 8'h10, 5'b00000, 4, 8'h10, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hA0, 8'h40, 5'b00000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hA0, 8'h40, 5'b01000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hA4, 8'h40, 5'b00000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hA4, 8'h40, 5'b01000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hA8, 8'h40, 5'b01000, 3, 8'h01, 8'h02, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hAC, 8'h40, 5'b00000, 3, 8'h01, 8'h02, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h90, 8'h40, 5'b10000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'h90, 8'h40, 5'b00000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h94, 8'h40, 5'b00000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'h94, 8'h40, 5'b01000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h94, 8'h40, 5'b10000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h98, 8'h40, 5'b00100, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'h9C, 8'h40, 5'b00100, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'h9C, 8'h40, 5'b00000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hB0, 8'h40, 5'b00010, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hB4, 8'h40, 5'b00010, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hB8, 8'h40, 5'b00000, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hB8, 8'h40, 5'b00001, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hBC, 8'h40, 5'b00000, 4, 8'h40, 8'h02, 1, 0, 4'd0, 0));
    vecs.push_back(mk(8'hBC, 8'h40, 5'b00001, 4, 8'h02, 8'h0A, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hC0, 8'h40, 5'b00000, 3, 8'h01, 8'h02, 0, 0, 4'd0, 0));
    vecs.push_back(mk(8'hD0, 8'h40, 5'b00000, 3, 8'h01, 8'h02, 0, 0, 4'd0, 0));
    foreach (vecs[i]) run_vec(vecs[i]);
    // jump to 0xFF, then LDA whose operand byte sits at 0x00 after the PC wraps
    cur_ins = 8'h80;
    clear_img();
    img[0] = 8'h80;
    img[1] = 8'hFF;
    img[8'hFF] = 8'h20;
    {fn, fz, fv, fc, fb} = 5'b00000;
    do_reset();
    window(4, o);
    chk("wrap_jmp_pc", pc_out, 8'hFF);
    cur_ins = 8'h20;
    window(6, o);
    chk("wrap_incm", o.incm, 8'h0A);
    chk("wrap_exec_addr", o.a5, 8'h80);
    chk("wrap_operand", o.opd, 8'h5A);
    chk("wrap_pc", pc_out, 8'h01);
    // NOP, SHL, HLT then idle in HALT
    cur_ins = 8'hF0;
    clear_img();
    img[0] = 8'h00;
    img[1] = 8'hE1;
    img[2] = 8'hF0;
    do_reset();
    window(3, o);
    chk("seq_nop_acl", o.acl, 0);
    window(3, o);
    chk("seq_shl_acl", o.acl, 1);
    chk("seq_shl_alu", o.alu, 4'd7);
    window(3, o);
    chk("seq_hlt_incm", o.incm, 8'h02);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("halt_state", {halt, pc_inc, pc_load, ac_load, mem_we, pc_out}, {5'b10000, 8'h03});
      @(negedge clk);
    end
    // reset asserted during the EXEC cycle of STA
    cur_ins = 8'h10;
    clear_img();
    img[0] = 8'h10;
    img[1] = 8'h30;
    do_reset();
    window(4, o);
    #1;
    chk("sta_exec_we", {mem_we, mem_addr}, {1'b1, 8'h30});
    #1;
    reset = 1'b0;
    #1;
    chk("sta_reset_we", mem_we, 0);
    chk("sta_reset_ir", ir, 0);
    chk("sta_reset_addr", mem_addr, 8'h00);
    @(posedge clk);
    #1;
    chk("sta_no_write", mem[8'h30], 8'h77);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("restart_fetch", {mem_addr, pc_inc}, {8'h00, 1'b0});
    @(negedge clk);
    #1;
    chk("restart_ir_inc", pc_inc, 1);
    @(negedge clk);
    #1;
    chk("restart_ir", ir, 8'h10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
